// File: rtl/mor1kx_wb_result_cappuccino.sv
// rtl/mor1kx_wb_result_cappuccino.sv - writeback result select, load buffer and GPR write strobe.
// Optional `MOR1KX_WB_R0_PROTECT_EN suppresses writes to r0.
module mor1kx_wb_result_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
  input  logic                            ctrl_op_jal_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_ctrl_i,
  input  logic                            ctrl_exception_i,
  output logic                            ctrl_load_ready_o,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int A = OPTION_RF_ADDR_WIDTH;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_HELD = 1'b1
  } ld_state_t;

  ld_state_t      r_ld_state;
  ld_state_t      w_ld_next;
  logic [W-1:0]   r_ld_data;
  logic [W-1:0]   w_ld_raw;
  logic [W-1:0]   w_ld_ext;
  logic [W-1:0]   w_jal_result;
  logic [W-1:0]   w_result;
  logic           w_wb_adv;
  logic           w_rf_wb;
  logic           r_rf_wb;
  logic [A-1:0]   r_rfd_adr;
  logic [W-1:0]   r_result;

  // A flushed advance is not an advance at all.
  assign w_wb_adv = padv_wb_i & ~pipeline_flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_state <= LD_IDLE;
    end else begin
      r_ld_state <= w_ld_next;
    end
  end

  always_comb begin
    w_ld_next = r_ld_state;
    if (pipeline_flush_i) begin
      w_ld_next = LD_IDLE;
    end else begin
      case (r_ld_state)
        LD_IDLE: if (lsu_valid_i && !padv_wb_i) w_ld_next = LD_HELD;
        LD_HELD: if (padv_wb_i) w_ld_next = LD_IDLE;
        default: w_ld_next = LD_IDLE;
      endcase
    end
  end

  // Fresh load data always beats the held copy.
  always_comb begin
    ctrl_load_ready_o = (r_ld_state == LD_HELD) | lsu_valid_i;
    w_ld_raw          = lsu_valid_i ? lsu_result_i : r_ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_data <= '0;
    end else if (lsu_valid_i && !padv_wb_i && !pipeline_flush_i) begin
      r_ld_data <= lsu_result_i;
    end
  end

  always_comb begin
    case (ctrl_lsu_length_i)
      2'b00:   w_ld_ext = ctrl_lsu_zext_i ? {{(W-8){1'b0}}, w_ld_raw[7:0]}
                                          : {{(W-8){w_ld_raw[7]}}, w_ld_raw[7:0]};
      2'b01:   w_ld_ext = ctrl_lsu_zext_i ? {{(W-16){1'b0}}, w_ld_raw[15:0]}
                                          : {{(W-16){w_ld_raw[15]}}, w_ld_raw[15:0]};
      default: w_ld_ext = w_ld_raw;
    endcase
  end

  assign w_jal_result = pc_ctrl_i + W'(8);

  always_comb begin
    if (ctrl_op_lsu_load_i) begin
      w_result = w_ld_ext;
    end else if (ctrl_op_mfspr_i) begin
      w_result = mfspr_dat_i;
    end else if (ctrl_op_jal_i) begin
      w_result = w_jal_result;
    end else begin
      w_result = ctrl_alu_result_i;
    end
  end

`ifdef MOR1KX_WB_R0_PROTECT_EN
  assign w_rf_wb = ctrl_rf_wb_i & ~ctrl_exception_i & (|ctrl_rfd_adr_i);
`else
  assign w_rf_wb = ctrl_rf_wb_i & ~ctrl_exception_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wb   <= 1'b0;
      r_rfd_adr <= '0;
      r_result  <= '0;
    end else begin
      r_rf_wb <= w_wb_adv & w_rf_wb;
      if (w_wb_adv) begin
        r_rfd_adr <= ctrl_rfd_adr_i;
        r_result  <= w_result;
      end
    end
  end

  assign wb_rf_wb_o   = r_rf_wb;
  assign wb_rfd_adr_o = r_rfd_adr;
  assign result_o     = r_result;

endmodule

// File: tb/tb_mor1kx_wb_result_cappuccino.sv
// tb/tb_mor1kx_wb_result_cappuccino.sv - directed self-checking bench for the writeback stage.
module tb_mor1kx_wb_result_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_wb_i;
  logic        pipeline_flush_i;
  logic        ctrl_rf_wb_i;
  logic [4:0]  ctrl_rfd_adr_i;
  logic [31:0] ctrl_alu_result_i;
  logic        ctrl_op_lsu_load_i;
  logic [1:0]  ctrl_lsu_length_i;
  logic        ctrl_lsu_zext_i;
  logic        lsu_valid_i;
  logic [31:0] lsu_result_i;
  logic        ctrl_op_mfspr_i;
  logic [31:0] mfspr_dat_i;
  logic        ctrl_op_jal_i;
  logic [31:0] pc_ctrl_i;
  logic        ctrl_exception_i;
  logic        ctrl_load_ready_o;
  logic        wb_rf_wb_o;
  logic [4:0]  wb_rfd_adr_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mor1kx_wb_result_cappuccino dut (
    .clk               (clk),
    .rst               (rst),
    .padv_wb_i         (padv_wb_i),
    .pipeline_flush_i  (pipeline_flush_i),
    .ctrl_rf_wb_i      (ctrl_rf_wb_i),
    .ctrl_rfd_adr_i    (ctrl_rfd_adr_i),
    .ctrl_alu_result_i (ctrl_alu_result_i),
    .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i),
    .ctrl_lsu_length_i (ctrl_lsu_length_i),
    .ctrl_lsu_zext_i   (ctrl_lsu_zext_i),
    .lsu_valid_i       (lsu_valid_i),
    .lsu_result_i      (lsu_result_i),
    .ctrl_op_mfspr_i   (ctrl_op_mfspr_i),
    .mfspr_dat_i       (mfspr_dat_i),
    .ctrl_op_jal_i     (ctrl_op_jal_i),
    .pc_ctrl_i         (pc_ctrl_i),
    .ctrl_exception_i  (ctrl_exception_i),
    .ctrl_load_ready_o (ctrl_load_ready_o),
    .wb_rf_wb_o        (wb_rf_wb_o),
    .wb_rfd_adr_o      (wb_rfd_adr_o),
    .result_o          (result_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    padv_wb_i = 0; pipeline_flush_i = 0; ctrl_rf_wb_i = 0; ctrl_rfd_adr_i = 0;
    ctrl_alu_result_i = 0; ctrl_op_lsu_load_i = 0; ctrl_lsu_length_i = 2'b10;
    ctrl_lsu_zext_i = 0; lsu_valid_i = 0; lsu_result_i = 0; ctrl_op_mfspr_i = 0;
    mfspr_dat_i = 0; ctrl_op_jal_i = 0; pc_ctrl_i = 0; ctrl_exception_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; padv_wb_i = 1; lsu_valid_i = 1; pipeline_flush_i = 1;
    ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd7; ctrl_alu_result_i = 32'hDEAD_BEEF;
    tick(); tick();
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", wb_rf_wb_o); end
    n_cmp++; if (wb_rfd_adr_o !== 5'd0) begin n_bad++; $display("FAIL reset_adr: got %0d want 0", wb_rfd_adr_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    clear_inputs(); rst = 0; #1;
    n_cmp++; if (ctrl_load_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ld_idle: got %b want 0", ctrl_load_ready_o); end
  endtask

  task automatic test_word_load();
    clear_inputs();
    ctrl_op_lsu_load_i = 1; ctrl_lsu_length_i = 2'b10;
    lsu_valid_i = 1; lsu_result_i = 32'h8000_00FF; #1;
    n_cmp++; if (ctrl_load_ready_o !== 1'b1) begin n_bad++; $display("FAIL word_ready_strobe: got %b want 1", ctrl_load_ready_o); end
    tick();
    lsu_valid_i = 0; lsu_result_i = 32'h1111_1111; #1;
    n_cmp++; if (ctrl_load_ready_o !== 1'b1) begin n_bad++; $display("FAIL word_ready_held: got %b want 1", ctrl_load_ready_o); end
    tick();
    padv_wb_i = 1; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd5;
    tick();
    padv_wb_i = 0;
    n_cmp++; if (result_o !== 32'h8000_00FF) begin n_bad++; $display("FAIL word_result: got %h want 800000ff", result_o); end
    n_cmp++; if (wb_rf_wb_o !== 1'b1) begin n_bad++; $display("FAIL word_strobe: got %b want 1", wb_rf_wb_o); end
    n_cmp++; if (wb_rfd_adr_o !== 5'd5) begin n_bad++; $display("FAIL word_adr: got %0d want 5", wb_rfd_adr_o); end
    tick();
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL word_strobe_one_cycle: got %b want 0", wb_rf_wb_o); end
    n_cmp++; if (result_o !== 32'h8000_00FF) begin n_bad++; $display("FAIL word_result_hold: got %h want 800000ff", result_o); end
    n_cmp++; if (ctrl_load_ready_o !== 1'b0) begin n_bad++; $display("FAIL word_ld_released: got %b want 0", ctrl_load_ready_o); end
  endtask

  task automatic test_extend();
    logic [1:0]  len [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    logic        zx  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] din [6] = '{32'h0000_0080, 32'h0000_0080, 32'h0001_8001,
                             32'hFFFF_8001, 32'h8000_0001, 32'h7F00_00F0};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                             32'h0000_8001, 32'h8000_0001, 32'h7F00_00F0};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      ctrl_op_lsu_load_i = 1; ctrl_lsu_length_i = len[i]; ctrl_lsu_zext_i = zx[i];
      lsu_valid_i = 1; lsu_result_i = din[i]; padv_wb_i = 1; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd3;
      tick();
      clear_inputs(); #1;
      n_cmp++; if (result_o !== exp[i]) begin n_bad++; $display("FAIL extend_%0d: got %h want %h", i, result_o, exp[i]); end
      n_cmp++; if (ctrl_load_ready_o !== 1'b0) begin n_bad++; $display("FAIL extend_stay_idle_%0d: got %b want 0", i, ctrl_load_ready_o); end
    end
  endtask

  task automatic test_jal();
    clear_inputs();
    ctrl_op_jal_i = 1; pc_ctrl_i = 32'hFFFF_FFFC; ctrl_rfd_adr_i = 5'd9;
    ctrl_rf_wb_i = 1; ctrl_alu_result_i = 32'h5555_5555; padv_wb_i = 1;
    tick();
    clear_inputs();
    n_cmp++; if (result_o !== 32'h0000_0004) begin n_bad++; $display("FAIL jal_result: got %h want 00000004", result_o); end
    n_cmp++; if (wb_rfd_adr_o !== 5'd9) begin n_bad++; $display("FAIL jal_adr: got %0d want 9", wb_rfd_adr_o); end
    n_cmp++; if (wb_rf_wb_o !== 1'b1) begin n_bad++; $display("FAIL jal_strobe: got %b want 1", wb_rf_wb_o); end
  endtask

  task automatic test_priority();
    clear_inputs();
    ctrl_op_lsu_load_i = 1; ctrl_op_mfspr_i = 1; ctrl_op_jal_i = 1;
    lsu_valid_i = 1; lsu_result_i = 32'hA0A0_A0A0; mfspr_dat_i = 32'hB0B0_B0B0;
    pc_ctrl_i = 32'h0000_1000; ctrl_alu_result_i = 32'hC0C0_C0C0; padv_wb_i = 1;
    tick();
    n_cmp++; if (result_o !== 32'hA0A0_A0A0) begin n_bad++; $display("FAIL prio_load: got %h want a0a0a0a0", result_o); end
    ctrl_op_lsu_load_i = 0; lsu_valid_i = 0;
    tick();
    n_cmp++; if (result_o !== 32'hB0B0_B0B0) begin n_bad++; $display("FAIL prio_mfspr: got %h want b0b0b0b0", result_o); end
    ctrl_op_mfspr_i = 0;
    tick();
    n_cmp++; if (result_o !== 32'h0000_1008) begin n_bad++; $display("FAIL prio_jal: got %h want 00001008", result_o); end
    ctrl_op_jal_i = 0;
    tick();
    n_cmp++; if (result_o !== 32'hC0C0_C0C0) begin n_bad++; $display("FAIL prio_alu: got %h want c0c0c0c0", result_o); end
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL no_rf_wb_no_strobe: got %b want 0", wb_rf_wb_o); end
    clear_inputs(); tick();
  endtask

  task automatic test_overwrite();
    clear_inputs();
    ctrl_op_lsu_load_i = 1; lsu_valid_i = 1; lsu_result_i = 32'h0000_0001;
    tick();
    lsu_result_i = 32'h0000_0002;
    tick();
    lsu_valid_i = 0; lsu_result_i = 32'h0000_0003;
    tick();
    padv_wb_i = 1; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd12;
    tick();
    clear_inputs();
    n_cmp++; if (result_o !== 32'h0000_0002) begin n_bad++; $display("FAIL held_overwrite: got %h want 00000002", result_o); end
  endtask

  task automatic test_flush();
    clear_inputs();
    ctrl_alu_result_i = 32'h0BAD_F00D; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd6; padv_wb_i = 1;
    tick();
    clear_inputs();
    ctrl_op_lsu_load_i = 1; lsu_valid_i = 1; lsu_result_i = 32'hAAAA_5555;
    tick();
    lsu_valid_i = 0; padv_wb_i = 1; pipeline_flush_i = 1; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd8;
    tick();
    clear_inputs(); #1;
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL flush_strobe: got %b want 0", wb_rf_wb_o); end
    n_cmp++; if (ctrl_load_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ld_idle: got %b want 0", ctrl_load_ready_o); end
    n_cmp++; if (result_o !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL flush_result_kept: got %h want 0badf00d", result_o); end
    n_cmp++; if (wb_rfd_adr_o !== 5'd6) begin n_bad++; $display("FAIL flush_adr_kept: got %0d want 6", wb_rfd_adr_o); end
  endtask

  task automatic test_exception();
    clear_inputs();
    ctrl_alu_result_i = 32'h0000_1234; ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd4;
    ctrl_exception_i = 1; padv_wb_i = 1;
    tick();
    clear_inputs();
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL exc_strobe: got %b want 0", wb_rf_wb_o); end
    n_cmp++; if (result_o !== 32'h0000_1234) begin n_bad++; $display("FAIL exc_result: got %h want 00001234", result_o); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ctrl_rf_wb_i = 1; padv_wb_i = 1; ctrl_alu_result_i = 32'h11; ctrl_rfd_adr_i = 5'd3;
    tick();
    ctrl_alu_result_i = 32'h22; ctrl_rfd_adr_i = 5'd4;
    n_cmp++; if (wb_rf_wb_o !== 1'b1 || result_o !== 32'h11 || wb_rfd_adr_o !== 5'd3) begin
      n_bad++; $display("FAIL b2b_first: got %b/%h/%0d want 1/00000011/3", wb_rf_wb_o, result_o, wb_rfd_adr_o); end
    tick();
    clear_inputs();
    n_cmp++; if (wb_rf_wb_o !== 1'b1 || result_o !== 32'h22 || wb_rfd_adr_o !== 5'd4) begin
      n_bad++; $display("FAIL b2b_second: got %b/%h/%0d want 1/00000022/4", wb_rf_wb_o, result_o, wb_rfd_adr_o); end
    tick();
    n_cmp++; if (wb_rf_wb_o !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", wb_rf_wb_o); end
  endtask

  task automatic test_r0();
    logic exp_strobe;
`ifdef MOR1KX_WB_R0_PROTECT_EN
    exp_strobe = 1'b0;
`else
    exp_strobe = 1'b1;
`endif
    clear_inputs();
    ctrl_rf_wb_i = 1; ctrl_rfd_adr_i = 5'd0; ctrl_alu_result_i = 32'h77; padv_wb_i = 1;
    tick();
    clear_inputs();
    n_cmp++; if (wb_rf_wb_o !== exp_strobe) begin n_bad++; $display("FAIL r0_strobe: got %b want %b", wb_rf_wb_o, exp_strobe); end
    n_cmp++; if (result_o !== 32'h77) begin n_bad++; $display("FAIL r0_result: got %h want 00000077", result_o); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_extend();
    test_jal();
    test_priority();
    test_overwrite();
    test_flush();
    test_exception();
    test_back_to_back();
    test_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
